// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module      : mdu_hilo
// Description : Iterative multiply/divide unit holding the HI/LO register
//               pair. Executes MULT, MULTU, DIV and DIVU in a fixed 33-cycle
//               run (32 iterations + 1 fix-up cycle) and supports MTHI/MTLO.
//
// Ports       : clk, rst_n        clock, asynchronous active-low reset
//               A, B              operands (rs, rt)
//               MDFun             00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//               start             launch MDFun on A, B (ignored while busy)
//               mthi, mtlo        write A into HI / LO (idle, no start)
//               HI, LO            result registers
//               busy              operation in progress
//               done              one-cycle pulse, HI/LO hold new result
//               DivZero           last divide had B == 0
//
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       MDFun,
    input  logic             start,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done,
    output logic             DivZero
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_fix  = 2'd2;

    localparam logic [4:0] c_last_iter = 5'd31;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [4:0]         r_count;
    logic               r_is_div;
    logic               r_sa;
    logic               r_sb;
    logic               r_bzero;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   r_opa;       // |A|: multiplicand or (unused) for divide
    logic [WIDTH-1:0]   r_opb;       // |B|: divisor
    logic [2*WIDTH-1:0] r_acc;       // multiply accumulator, multiplier in low half
    logic [WIDTH-1:0]   r_rem;       // divide partial remainder (always < divisor)
    logic [WIDTH-1:0]   r_quot;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_div_zero;

    logic               w_signed_op;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_fits;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // ------------------------------------------------------------------
    // Operand conditioning. Negating 0x80000000 yields 0x80000000, which
    // read as unsigned is exactly its magnitude.
    // ------------------------------------------------------------------
    assign w_signed_op = ~MDFun[0];
    assign w_abs_a     = (w_signed_op && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign w_abs_b     = (w_signed_op && B[WIDTH-1]) ? (~B + 1'b1) : B;

    // Multiply step: conditional add into the upper half with carry out;
    // the carry becomes the new MSB after the right shift.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});

    // Divide step: the shifted remainder needs one extra bit. When the trial
    // subtraction succeeds the true difference is below the divisor, so the
    // low WIDTH bits of a WIDTH-bit subtraction are exact.
    assign w_div_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_div_fits  = (w_div_shift >= {1'b0, r_opb});
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opb;

    // Sign fix-up for the final write.
    assign w_prod_fix = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;
    assign w_quot_fix = (r_sa ^ r_sb) ? (~r_quot + 1'b1) : r_quot;
    assign w_rem_fix  = r_sa ? (~r_rem + 1'b1) : r_rem;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_nxt = c_st_run;
            c_st_run:  if (r_count == c_last_iter) w_state_nxt = c_st_fix;
            c_st_fix:  w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_is_div   <= 1'b0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_bzero    <= 1'b0;
            r_a_orig   <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_acc      <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        // start takes priority; any concurrent move is dropped
                        r_count    <= '0;
                        r_is_div   <= MDFun[1];
                        r_sa       <= w_signed_op & A[WIDTH-1];
                        r_sb       <= w_signed_op & B[WIDTH-1];
                        r_bzero    <= (B == '0);
                        r_a_orig   <= A;
                        r_opa      <= w_abs_a;
                        r_opb      <= w_abs_b;
                        r_acc      <= {{WIDTH{1'b0}}, w_abs_b};
                        r_rem      <= '0;
                        r_quot     <= w_abs_a;
                        r_div_zero <= 1'b0;
                    end else begin
                        if (mthi) r_hi <= A;
                        if (mtlo) r_lo <= A;
                    end
                end
                c_st_run: begin
                    r_count <= r_count + 1'b1;
                    if (r_is_div) begin
                        r_rem  <= w_div_fits ? w_div_diff : w_div_shift[WIDTH-1:0];
                        r_quot <= {r_quot[WIDTH-2:0], w_div_fits};
                    end else begin
                        r_acc  <= {w_mul_sum, r_acc[WIDTH-1:1]};
                    end
                end
                c_st_fix: begin
                    r_done <= 1'b1;
                    if (!r_is_div) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else if (r_bzero) begin
                        // divide by zero: all-ones quotient, dividend as remainder
                        r_hi       <= r_a_orig;
                        r_lo       <= '1;
                        r_div_zero <= 1'b1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign HI      = r_hi;
    assign LO      = r_lo;
    assign busy    = (r_state != c_st_idle);
    assign done    = r_done;
    assign DivZero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_hilo
// Description : Self-checking bench for mdu_hilo. Expected HI/LO/DivZero come
//               from a native-arithmetic reference model, queued at launch and
//               compared when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_hilo;

    typedef struct packed {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  MDFun;
    logic        start;
    logic        mthi;
    logic        mtlo;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;
    logic        DivZero;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t sb_q[$];
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        prev_done = 1'b0;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .MDFun   (MDFun),
        .start   (start),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .HI      (HI),
        .LO      (LO),
        .busy    (busy),
        .done    (done),
        .DivZero (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [1:0] fun, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        longint      p;
        longint      sa;
        longint      sbv;
        longint      q;
        longint      rm;
        logic [63:0] u;
        r = '0;
        case (fun)
            2'b00: begin
                p = longint'($signed(a)) * longint'($signed(b));
                u = p;
                r.hi = u[63:32];
                r.lo = u[31:0];
            end
            2'b01: begin
                u = {32'b0, a} * {32'b0, b};
                r.hi = u[63:32];
                r.lo = u[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    r.dz = 1'b1;
                    r.lo = 32'hFFFF_FFFF;
                    r.hi = a;
                end else if (fun == 2'b10) begin
                    sa  = longint'($signed(a));
                    sbv = longint'($signed(b));
                    q   = sa / sbv;
                    rm  = sa % sbv;
                    u   = q;
                    r.lo = u[31:0];
                    u   = rm;
                    r.hi = u[31:0];
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest queued result.
    always @(posedge clk) begin
        res_t e;
        #1;
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", {63'b0, done}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("result_hi", {32'b0, HI}, {32'b0, e.hi});
                chk("result_lo", {32'b0, LO}, {32'b0, e.lo});
                chk("result_divzero", {63'b0, DivZero}, {63'b0, e.dz});
                chk("busy_at_done", {63'b0, busy}, 64'd0);
                exp_hi = e.hi;
                exp_lo = e.lo;
            end
            chk("done_single_cycle", {63'b0, prev_done}, 64'd0);
        end
        prev_done = done;
    end

    // Drives start for one edge; returns #1 after the accepting edge.
    task automatic launch(input logic [1:0] fun, input logic [31:0] a, input logic [31:0] b,
                          input bit expect_done, input bit with_mtlo);
        if (expect_done) sb_q.push_back(model(fun, a, b));
        @(negedge clk);
        MDFun = fun;
        A     = a;
        B     = b;
        start = 1'b1;
        mtlo  = with_mtlo;
        @(posedge clk);
        #1;
        start = 1'b0;
        mtlo  = 1'b0;
    endtask

    // Waits for done; 'elapsed' is the number of edges already past the start edge.
    task automatic wait_done(input int elapsed);
        int n;
        n = elapsed;
        while (!done && n < 45) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("start_to_done_latency", 64'(n), 64'd33);
    endtask

    task automatic run_op(input logic [1:0] fun, input logic [31:0] a, input logic [31:0] b);
        launch(fun, a, b, 1'b1, 1'b0);
        chk("busy_after_start", {63'b0, busy}, 64'd1);
        wait_done(0);
    endtask

    initial begin
        rst_n = 1'b0;
        A = '0; B = '0; MDFun = '0;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hi", {32'b0, HI}, 64'd0);
        chk("reset_lo", {32'b0, LO}, 64'd0);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_divzero", {63'b0, DivZero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MTHI alone, then MTHI+MTLO together
        @(negedge clk);
        A = 32'hAAAA_5555; mthi = 1'b1;
        @(posedge clk); #1; mthi = 1'b0;
        chk("mthi_hi", {32'b0, HI}, 64'h0000_0000_AAAA_5555);
        chk("mthi_lo_kept", {32'b0, LO}, 64'd0);
        @(negedge clk);
        A = 32'h1357_9BDF; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
        chk("mthi_mtlo_hi", {32'b0, HI}, 64'h0000_0000_1357_9BDF);
        chk("mthi_mtlo_lo", {32'b0, LO}, 64'h0000_0000_1357_9BDF);
        exp_hi = 32'h1357_9BDF;
        exp_lo = 32'h1357_9BDF;

        // Directed operations (launched back-to-back in the done cycle)
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b11, 32'd7, 32'd2);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 32'd100, 32'hFFFF_FFF9);

        // Divide by zero: flag held while idle, cleared by the next start
        run_op(2'b11, 32'h0000_1234, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("divzero_held", {63'b0, DivZero}, 64'd1);
        launch(2'b10, 32'hFFFF_0000, 32'd0, 1'b1, 1'b1);  // signed DIV by zero, with mtlo
        chk("divzero_cleared_on_start", {63'b0, DivZero}, 64'd0);
        chk("mtlo_dropped_with_start", {32'b0, LO}, {32'b0, exp_lo});
        wait_done(0);

        // start + mthi + operand changes while busy are ignored
        launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        MDFun = 2'b11; A = 32'hDEAD_BEEF; B = 32'd0; start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        chk("hi_unchanged_while_busy", {32'b0, HI}, {32'b0, exp_hi});
        chk("lo_unchanged_while_busy", {32'b0, LO}, {32'b0, exp_lo});
        A = 32'h5555_AAAA; B = 32'h0000_0003;
        wait_done(4);

        // Random operations
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : (i[0] ? ($urandom & 32'h0000_FFFF) : $urandom);
            run_op(2'($urandom_range(0, 3)), ra, rb);
        end

        // Make HI/LO non-zero, then abort a DIV with reset at cycle 10
        run_op(2'b01, 32'd3, 32'd0000_0005);
        chk("pre_abort_lo_nonzero", {32'b0, LO}, 64'd15);
        launch(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("abort_hi", {32'b0, HI}, 64'd0);
        chk("abort_lo", {32'b0, LO}, 64'd0);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        chk("post_abort_hi", {32'b0, HI}, 64'd0);
        chk("post_abort_lo", {32'b0, LO}, 64'd0);
        chk("post_abort_busy", {63'b0, busy}, 64'd0);

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
